// File: rtl/data_memory_ctrl.sv
// Byte-enabled data memory for the MEM stage: valid/ready request port, registered
// read, lane-legality checking and a hardware clear sequence after reset.
module data_memory_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                                                i_clk,
  input  logic                                                i_reset,
  input  logic                                                i_req_valid,
  output logic                                                o_req_ready,
  input  logic                                                i_req_write,
  input  logic [$clog2(DEPTH)+$clog2(DATA_WIDTH/8)-1:0]       i_req_addr,
  input  logic [DATA_WIDTH/8-1:0]                             i_req_byte_enable,
  input  logic [DATA_WIDTH-1:0]                               i_req_wdata,
  output logic                                                o_rsp_valid,
  output logic [DATA_WIDTH-1:0]                               o_rsp_rdata,
  output logic                                                o_rsp_error,
  output logic                                                o_busy
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int OFF_W      = $clog2(BYTES);
  localparam int WORD_W     = $clog2(DEPTH);
  localparam int ADDR_WIDTH = WORD_W + OFF_W;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t             r_state;
  logic [WORD_W-1:0]  r_clr_cnt;
  logic               r_ready;
  logic               r_rsp_valid;
  logic               r_rsp_error;

  logic [WORD_W-1:0]  w_word;
  logic [OFF_W-1:0]   w_off;
  logic [WORD_W-1:0]  w_ram_addr;
  logic               w_accept;
  logic               w_legal;
  logic               w_load;
  logic               w_store;
  logic               w_clearing;

  assign w_word     = i_req_addr[ADDR_WIDTH-1:OFF_W];
  assign w_off      = i_req_addr[OFF_W-1:0];
  assign w_accept   = i_req_valid & o_req_ready;
  assign w_load     = w_accept & ~i_req_write & w_legal;
  assign w_store    = w_accept & i_req_write & w_legal;
  assign w_clearing = (r_state == S_CLEAR) & ~i_reset;
  assign w_ram_addr = w_clearing ? r_clr_cnt : w_word;

  // Reset masks ready and the response strobe in the same cycle, so a response
  // still in flight when reset arrives is never seen by the consumer.
  assign o_req_ready = r_ready & ~i_reset;
  assign o_busy      = ~o_req_ready;
  assign o_rsp_valid = r_rsp_valid & ~i_reset;
  assign o_rsp_error = r_rsp_error;

  // Legal: single lane, even-aligned lane pair, or full word; the byte offset
  // must name the lowest enabled lane.
  always_comb begin
    w_legal = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      if (i_req_byte_enable == (BYTES'(1) << i) && w_off == OFF_W'(i))
        w_legal = 1'b1;
    end
    for (int i = 0; i < BYTES - 1; i += 2) begin
      if (i_req_byte_enable == (BYTES'(3) << i) && w_off == OFF_W'(i))
        w_legal = 1'b1;
    end
    if (i_req_byte_enable == {BYTES{1'b1}} && w_off == '0)
      w_legal = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_CLEAR;
      r_clr_cnt   <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_accept)
        r_rsp_error <= ~w_legal;
      unique case (r_state)
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == WORD_W'(DEPTH - 1)) begin
            r_state <= S_READY;
            r_ready <= 1'b1;
          end
        end
        S_READY: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // One RAM per byte lane keeps byte-enable writes as plain per-array writes.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : lane_g
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_q;
      logic       w_we;
      logic [7:0] w_wdata;

      assign w_we    = w_clearing | (w_store & i_req_byte_enable[gi]);
      assign w_wdata = w_clearing ? 8'h00 : i_req_wdata[gi*8 +: 8];

      always_ff @(posedge i_clk) begin
        if (w_we)
          r_mem[w_ram_addr] <= w_wdata;
      end

      // Output register is zeroed for stores, errors and disabled load lanes.
      always_ff @(posedge i_clk) begin
        if (i_reset || (w_accept && !(w_load && i_req_byte_enable[gi])))
          r_q <= 8'h00;
        else if (w_accept)
          r_q <= r_mem[w_word];
      end

      assign o_rsp_rdata[gi*8 +: 8] = r_q;
    end
  endgenerate

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: clear sequence, loads/stores, lane checks,
// back-to-back stream and reset during an outstanding response.
module tb_data_memory_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  data_memory_ctrl #(.DATA_WIDTH(32), .DEPTH(256)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_req_valid       (req_valid),
    .o_req_ready       (req_ready),
    .i_req_write       (req_write),
    .i_req_addr        (req_addr),
    .i_req_byte_enable (req_be),
    .i_req_wdata       (req_wdata),
    .o_rsp_valid       (rsp_valid),
    .o_rsp_rdata       (rsp_rdata),
    .o_rsp_error       (rsp_error),
    .o_busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request for exactly one clock edge; returns 1ns after that edge,
  // when the response to this request is visible.
  task automatic req(input logic wr, input logic [9:0] addr, input logic [3:0] be,
                     input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    req_be    = 4'h0;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic e, input logic [31:0] d);
    $display("txn %s: we=%b addr=0x%03h be=%b wdata=0x%08h -> valid=%b error=%b rdata=0x%08h",
             tag, req_write, req_addr, req_be, req_wdata, rsp_valid, rsp_error, rsp_rdata);
    check({tag, "_valid"}, 32'(rsp_valid), 32'(v));
    check({tag, "_error"}, 32'(rsp_error), 32'(e));
    check({tag, "_rdata"}, rsp_rdata, d);
  endtask

  // Called with reset already asserted; holds it across one edge, releases it
  // and measures how long req_ready stays low.
  task automatic wait_clear(input string tag);
    int n;
    @(posedge clk);
    #1;
    check({tag, "_busy_in_reset"},  32'(busy),      32'd1);
    check({tag, "_ready_in_reset"}, 32'(req_ready), 32'd0);
    check({tag, "_valid_in_reset"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rdata_in_reset"}, rsp_rdata,      32'd0);
    check({tag, "_error_in_reset"}, 32'(rsp_error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n = 0;
    while (req_ready !== 1'b1 && n < 400) begin
      n++;
      @(posedge clk);
      #1;
    end
    $display("txn %s: clear sequence lasted %0d cycles", tag, n);
    check({tag, "_clear_cycles"}, 32'(n), 32'd256);
    check({tag, "_busy_after"},   32'(busy), 32'd0);
  endtask

  initial begin
    int bad;
    clk       = 1'b0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;

    // 1. power-on clear, then every word reads back zero
    wait_clear("por");
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      req(1'b0, 10'(i * 4), 4'hF, 32'h0);
      if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0)
        bad++;
    end
    $display("txn scan: 256 loads, %0d returned non-zero or bad status", bad);
    check("clear_scan_bad", 32'(bad), 32'd0);
    idle();
    @(posedge clk);
    #1;
    check("idle_no_valid", 32'(rsp_valid), 32'd0);

    // 2. word store then load of the same word on the next edge
    req(1'b1, 10'h010, 4'hF, 32'hDEADBEEF);
    chk_rsp("sw_010", 1'b1, 1'b0, 32'h0);
    req(1'b0, 10'h010, 4'hF, 32'h0);
    chk_rsp("lw_010", 1'b1, 1'b0, 32'hDEADBEEF);

    // 3. byte store into lane 2, then word and half loads
    req(1'b1, 10'h012, 4'b0100, 32'h00550000);
    chk_rsp("sb_012", 1'b1, 1'b0, 32'h0);
    req(1'b0, 10'h010, 4'hF, 32'h0);
    chk_rsp("lw_after_sb", 1'b1, 1'b0, 32'hDE55BEEF);
    req(1'b0, 10'h010, 4'b0011, 32'h0);
    chk_rsp("lh_lo", 1'b1, 1'b0, 32'h0000BEEF);
    req(1'b0, 10'h012, 4'b1100, 32'h0);
    chk_rsp("lh_hi", 1'b1, 1'b0, 32'hDE550000);

    // 4. illegal accesses leave memory untouched
    req(1'b1, 10'h011, 4'b0110, 32'hFFFFFFFF);
    chk_rsp("ill_pair_odd", 1'b1, 1'b1, 32'h0);
    req(1'b0, 10'h010, 4'hF, 32'h0);
    chk_rsp("lw_after_ill1", 1'b1, 1'b0, 32'hDE55BEEF);
    req(1'b1, 10'h011, 4'b0011, 32'hFFFFFFFF);
    chk_rsp("ill_off_mismatch", 1'b1, 1'b1, 32'h0);
    req(1'b0, 10'h010, 4'hF, 32'h0);
    chk_rsp("lw_after_ill2", 1'b1, 1'b0, 32'hDE55BEEF);
    req(1'b1, 10'h010, 4'b0000, 32'hFFFFFFFF);
    chk_rsp("ill_be_zero", 1'b1, 1'b1, 32'h0);
    req(1'b0, 10'h010, 4'hF, 32'h0);
    chk_rsp("lw_after_ill3", 1'b1, 1'b0, 32'hDE55BEEF);
    req(1'b0, 10'h011, 4'b0110, 32'h0);
    chk_rsp("ill_load", 1'b1, 1'b1, 32'h0);

    // 5. back-to-back stream
    req(1'b1, 10'h3FC, 4'hF, 32'h12345678);
    chk_rsp("bb_sw_3fc", 1'b1, 1'b0, 32'h0);
    req(1'b0, 10'h3FC, 4'hF, 32'h0);
    chk_rsp("bb_lw_3fc", 1'b1, 1'b0, 32'h12345678);
    req(1'b0, 10'h000, 4'hF, 32'h0);
    chk_rsp("bb_lw_000", 1'b1, 1'b0, 32'h0);

    // 6. reset right after a load is accepted
    req(1'b0, 10'h3FC, 4'hF, 32'h0);
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    check("rst_drops_rsp", 32'(rsp_valid), 32'd0);
    wait_clear("rst2");
    req(1'b0, 10'h3FC, 4'hF, 32'h0);
    chk_rsp("lw_3fc_after_rst", 1'b1, 1'b0, 32'h0);
    req(1'b0, 10'h010, 4'hF, 32'h0);
    chk_rsp("lw_010_after_rst", 1'b1, 1'b0, 32'h0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
